change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream stage of the vending/bar-code controller.
- Takes the change amount the controller computes (moneyToGive) and drives the coin mechanism.
- Pays greedily: 10-unit coins on DEZ, then 2-unit coins on DOIS.
- Each coin is a timed pulse, gated by a ready handshake from the mechanism; any unpayable residue is reported.

Parameters:
- WIDTH, 5, width of amount/remaining/residue
- BIG_COIN, 10, value paid per DEZ pulse
- SMALL_COIN, 2, value paid per DOIS pulse
- PULSE_CYCLES, 2, cycles each coin pulse stays high (≥1)
- GAP_CYCLES, 2, low cycles after each pulse (≥1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  request to pay `amount`; sampled only in IDLE
- amount  in  WIDTH  change to pay, unsigned
- mech_ready  in  1  coin mechanism can accept a pulse
- DEZ  out  1  10-unit coin pulse
- DOIS  out  1  2-unit coin pulse
- busy  out  1  high from the start edge until DONE is left
- done  out  1  one-cycle completion strobe
- short  out  1  valid with done: residue ≠ 0
- remaining  out  WIDTH  amount still to pay
- residue  out  WIDTH  unpaid amount, held from DONE until next start

Behaviour:
- Reset:
  - One clock is synchronous, active-low reset: reset=0 at a rising edge forces IDLE.
  - All outputs go to 0: DEZ, DOIS, busy, done, short, remaining, residue.
  - Applies mid-pulse; any pulse in progress is cut at that edge.
- All outputs are registered and decoded from the state and registers; no combinational input-to-output path.
- States: IDLE, DECIDE, PULSE, GAP, DONE.
- IDLE:
  - start=1 at an edge: remaining←amount, residue←0, short←0, busy←1.
  - Next state is DECIDE, or DONE if amount=0.
  - start=0: stay in IDLE.
- DECIDE:
  - If remaining ≥ BIG_COIN and mech_ready=1: select big, remaining←remaining−BIG_COIN, go to PULSE.
  - Else if remaining ≥ SMALL_COIN and mech_ready=1: select small, remaining←remaining−SMALL_COIN, go to PULSE.
  - Else if remaining < SMALL_COIN: residue←remaining, remaining←0, go to DONE.
  - Else (mech_ready=0): stay in DECIDE; no coin is selected and remaining is unchanged.
- PULSE:
  - DEZ (big) or DOIS (small) is high for exactly PULSE_CYCLES cycles, then go to GAP.
  - mech_ready is ignored in this state; a started pulse always completes.
- GAP: both coin outputs low for GAP_CYCLES cycles, then go to DECIDE.
- DONE:
  - done=1 and short=(residue≠0) for exactly one cycle; busy still 1.
  - Next state is IDLE, with busy=0 and done=0.
  - short is held until the next start.
- start while busy=1 is ignored. There is no queueing.
- DEZ and DOIS are never high in the same cycle.
- Arithmetic:
  - Subtraction only after a ≥ compare, so remaining never wraps.
  - Maximum amount 2^WIDTH−1 = 31 gives 10,10,10 paid and residue 1.
- Timing with defaults and mech_ready=1:
  - Each coin takes 5 cycles (DECIDE, 2×PULSE, 2×GAP).
  - done rises in cycle 5·N+2 after the start edge, where N is the number of coins.
- reset=0 together with start=1: reset wins.

Test Plan:
- Reset then amount=24, start 1 cycle, mech_ready=1 → pulses DEZ, DEZ, DOIS, DOIS, each 2 cycles high with 3-cycle spacing. remaining steps 14, 4, 2, 0. done in cycle 22; short=0; residue=0.
- amount=7 → DOIS ×3, then done with short=1, residue=1, DEZ never high.
- amount=31 → DEZ ×3, then residue=1, short=1, done in cycle 17. Then amount=0 → done in the cycle after start, no pulses, short=0.
- amount=20 with mech_ready=0 for 10 cycles after start → stays in DECIDE, no pulse, remaining=20. After mech_ready rises, first DEZ begins next cycle. mech_ready dropped mid-pulse → pulse still lasts 2 cycles.
- start=1 with amount=12 during a busy payout of 10 → ignored: only one DEZ, no DOIS, residue=0.
- reset=0 in the second DEZ cycle of amount=20 → next cycle all outputs 0 in IDLE. A fresh start with amount=2 pays exactly one DOIS.

Source files
------------

// File: rtl/change_dispenser.sv
// Greedy coin payout: BIG_COIN pulses on DEZ, then SMALL_COIN pulses on DOIS; each coin costs 1+PULSE+GAP cycles.
// Backpressure: a coin is only started when mech_ready is high in DECIDE; a started pulse always runs to completion.
module change_dispenser #(
    parameter int WIDTH        = 5,
    parameter int BIG_COIN     = 10,
    parameter int SMALL_COIN   = 2,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] amount,
    input  logic             mech_ready,
    output logic             DEZ,
    output logic             DOIS,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [WIDTH-1:0] remaining,
    output logic [WIDTH-1:0] residue
);

    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [WIDTH-1:0] BIG_AMT    = WIDTH'(BIG_COIN);
    localparam logic [WIDTH-1:0] SMALL_AMT  = WIDTH'(SMALL_COIN);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] residue_q, residue_d;
    logic             short_q, short_d;
    logic             big_q, big_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            residue_q   <= '0;
            short_q     <= 1'b0;
            big_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            residue_q   <= residue_d;
            short_q     <= short_d;
            big_q       <= big_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        residue_d   = residue_q;
        short_d     = short_q;
        big_d       = big_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = amount;
                    residue_d   = '0;
                    short_d     = 1'b0;
                    cnt_d       = '0;
                    state_d     = (amount == '0) ? S_DONE : S_DECIDE;
                end
            end

            // Every subtraction sits behind its >= compare, so remaining cannot wrap.
            S_DECIDE: begin
                if (remaining_q >= BIG_AMT && mech_ready) begin
                    big_d       = 1'b1;
                    remaining_d = remaining_q - BIG_AMT;
                    cnt_d       = '0;
                    state_d     = S_PULSE;
                end else if (remaining_q >= SMALL_AMT && mech_ready) begin
                    big_d       = 1'b0;
                    remaining_d = remaining_q - SMALL_AMT;
                    cnt_d       = '0;
                    state_d     = S_PULSE;
                end else if (remaining_q < SMALL_AMT) begin
                    residue_d   = remaining_q;
                    short_d     = (remaining_q != '0);
                    remaining_d = '0;
                    state_d     = S_DONE;
                end
            end

            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DECIDE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode only flopped state, so inputs never reach them combinationally.
    assign DEZ       = (state_q == S_PULSE) && big_q;
    assign DOIS      = (state_q == S_PULSE) && !big_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign short     = short_q;
    assign remaining = remaining_q;
    assign residue   = residue_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed vectors for change_dispenser: payout table plus stall, busy-start and mid-pulse reset sequences.
module tb_change_dispenser;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] amount;
    logic       mech_ready;
    logic       DEZ;
    logic       DOIS;
    logic       busy;
    logic       done;
    logic       short;
    logic [4:0] remaining;
    logic [4:0] residue;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    change_dispenser dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .amount     (amount),
        .mech_ready (mech_ready),
        .DEZ        (DEZ),
        .DOIS       (DOIS),
        .busy       (busy),
        .done       (done),
        .short      (short),
        .remaining  (remaining),
        .residue    (residue)
    );

    typedef struct {
        logic [4:0] amt;
        int         n_big;
        int         n_small;
        logic [4:0] res;
        int         done_cyc;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Full payout with mech_ready=1; checks coin order, pulse timing and final status.
    task automatic run_payout(input logic [4:0] amt, input int nb, input int ns,
                              input logic [4:0] res, input int dcyc, input string tag);
        int   cyc, nbig, nsmall, bad, k, len, exp_rem;
        logic pd, ps;
        nbig = 0; nsmall = 0; bad = 0; k = 0; len = 0; exp_rem = amt;
        pd = 1'b0; ps = 1'b0;
        amount = amt;
        start  = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        chk({tag, "_busy_start"}, busy, 1);
        while (done !== 1'b1 && cyc < 300) begin
            if (DEZ && DOIS) bad++;
            if ((DEZ && !pd) || (DOIS && !ps)) begin
                if (k < nb) begin
                    exp_rem -= 10;
                    if (!DEZ) bad++;
                end else begin
                    exp_rem -= 2;
                    if (!DOIS) bad++;
                end
                if (cyc != 5 * k + 2) bad++;
                if (int'(remaining) != exp_rem) bad++;
                k++;
                len = 0;
            end
            if (DEZ || DOIS) len++;
            else if ((pd || ps) && len != 2) bad++;
            if (DEZ && !pd) nbig++;
            if (DOIS && !ps) nsmall++;
            pd = DEZ;
            ps = DOIS;
            tick();
            cyc++;
        end
        if (DEZ || DOIS) bad++;
        chk({tag, "_done_cycle"}, cyc, dcyc);
        chk({tag, "_n_dez"}, nbig, nb);
        chk({tag, "_n_dois"}, nsmall, ns);
        chk({tag, "_pulse_shape"}, bad, 0);
        chk({tag, "_residue"}, residue, res);
        chk({tag, "_short"}, short, int'(res != 0));
        chk({tag, "_remaining"}, remaining, 0);
        chk({tag, "_busy_done"}, busy, 1);
        tick();
        chk({tag, "_done_drop"}, done, 0);
        chk({tag, "_busy_drop"}, busy, 0);
        chk({tag, "_short_hold"}, short, int'(res != 0));
        chk({tag, "_residue_hold"}, residue, res);
    endtask

    // Payout counting coins; optionally pulses start with amount=12 in cycle inj_cyc.
    task automatic wait_done(input logic [4:0] amt, input int inj_cyc,
                             output int nbig, output int nsmall, output int cyc);
        logic pd, ps;
        nbig = 0; nsmall = 0; pd = 1'b0; ps = 1'b0;
        amount = amt;
        start  = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 300) begin
            if (DEZ && !pd) nbig++;
            if (DOIS && !ps) nsmall++;
            pd = DEZ;
            ps = DOIS;
            start = (cyc == inj_cyc);
            if (cyc == inj_cyc) amount = 5'd12;
            tick();
            cyc++;
        end
        start = 1'b0;
    endtask

    initial begin
        int   nb, ns, cyc, stall_bad;
        logic pd;

        vecs[0] = '{5'd24, 2, 2, 5'd0, 22};
        vecs[1] = '{5'd7,  0, 3, 5'd1, 17};
        vecs[2] = '{5'd31, 3, 0, 5'd1, 17};
        vecs[3] = '{5'd0,  0, 0, 5'd0, 1};
        vecs[4] = '{5'd2,  0, 1, 5'd0, 7};
        vecs[5] = '{5'd10, 1, 0, 5'd0, 7};
        vecs[6] = '{5'd1,  0, 0, 5'd1, 2};
        vecs[7] = '{5'd13, 1, 1, 5'd1, 12};
        vecs[8] = '{5'd19, 1, 4, 5'd1, 27};

        reset      = 1'b0;
        start      = 1'b0;
        amount     = 5'd0;
        mech_ready = 1'b1;
        tick();
        tick();
        chk("rst_dez", DEZ, 0);
        chk("rst_dois", DOIS, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_short", short, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_residue", residue, 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_payout(vecs[i].amt, vecs[i].n_big, vecs[i].n_small, vecs[i].res,
                       vecs[i].done_cyc, $sformatf("vec%0d_amt%0d", i, vecs[i].amt));
        end

        // Stall in DECIDE while the mechanism is not ready.
        mech_ready = 1'b0;
        amount     = 5'd20;
        start      = 1'b1;
        tick();
        start     = 1'b0;
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (DEZ || DOIS || remaining != 5'd20 || !busy) stall_bad++;
            tick();
        end
        chk("stall_hold", stall_bad, 0);
        mech_ready = 1'b1;
        tick();
        chk("stall_dez_start", DEZ, 1);
        chk("stall_remaining", remaining, 10);
        mech_ready = 1'b0;
        tick();
        chk("stall_pulse_holds", DEZ, 1);
        tick();
        chk("stall_pulse_ends", DEZ, 0);
        mech_ready = 1'b1;
        nb  = 0;
        pd  = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (DEZ && !pd) nb++;
            pd = DEZ;
            tick();
            cyc++;
        end
        chk("stall_done_seen", done, 1);
        chk("stall_second_dez", nb, 1);
        chk("stall_residue", residue, 0);
        chk("stall_short", short, 0);
        tick();

        // start during a busy payout is ignored.
        wait_done(5'd10, 3, nb, ns, cyc);
        chk("busy_start_done_cycle", cyc, 7);
        chk("busy_start_n_dez", nb, 1);
        chk("busy_start_n_dois", ns, 0);
        chk("busy_start_residue", residue, 0);
        tick();
        chk("busy_start_idle", busy, 0);

        // Reset cuts a pulse in progress; reset also beats a simultaneous start.
        amount = 5'd20;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("midrst_pre_dez", DEZ, 1);
        reset = 1'b0;
        tick();
        chk("midrst_dez", DEZ, 0);
        chk("midrst_dois", DOIS, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_short", short, 0);
        chk("midrst_remaining", remaining, 0);
        chk("midrst_residue", residue, 0);
        start  = 1'b1;
        amount = 5'd2;
        tick();
        chk("rst_beats_start_busy", busy, 0);
        start = 1'b0;
        reset = 1'b1;
        tick();
        chk("post_rst_idle", busy, 0);
        run_payout(5'd2, 0, 1, 5'd0, 7, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
